// File: rtl/msrv32_pkg.sv
// ----------------------------------------------------------------------------
// msrv32_pkg
// Shared definitions for the machine-timer window: register offsets (word
// index within the 32-byte window), CTRL bit positions, reset constants and a
// byte-enable merge helper used by every writable register.
// ----------------------------------------------------------------------------
package msrv32_pkg;

  // Word offsets inside the timer window (address bits [4:2]).
  typedef enum logic [2:0] {
    OFF_MTIME_LO    = 3'd0,
    OFF_MTIME_HI    = 3'd1,
    OFF_MTIMECMP_LO = 3'd2,
    OFF_MTIMECMP_HI = 3'd3,
    OFF_CTRL        = 3'd4,
    OFF_PRESCALE    = 3'd5
  } mtimer_off_e;

  // CTRL register layout.
  localparam int unsigned CTRL_EN_BIT = 0;

  // Width of the prescale register / counter.
  localparam int unsigned PRESCALE_W = 16;

  // mtimecmp resets to all-ones so no interrupt fires before software
  // programs a compare value.
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace the bytes of old_val selected by mask with the matching bytes
  // of new_val.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/msrv32_mtimer_prescaler.sv
// ----------------------------------------------------------------------------
// msrv32_mtimer_prescaler
// Divides the clock down to mtime ticks: the counter runs 0..prescale and
// asserts tick on the cycle it equals prescale, then restarts from 0.
// A disabled timer freezes the counter; clear restarts it from 0.
// Only built when MSRV32_MTIMER_PRESCALER_EN is defined.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   en       - timer enable (CTRL.EN)
//   clear    - restart the count (software wrote PRESCALE)
//   prescale - divide value; a tick every prescale+1 enabled cycles
//   tick     - advance mtime this cycle
// ----------------------------------------------------------------------------
`ifdef MSRV32_MTIMER_PRESCALER_EN
module msrv32_mtimer_prescaler
  import msrv32_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count;

  assign tick = en && (count == prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      if (count == prescale) count <= '0;
      else                   count <= count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/msrv32_mtimer.sv
// ----------------------------------------------------------------------------
// msrv32_mtimer
// Memory-mapped RISC-V machine timer occupying a 32-byte window at BASE_ADDR:
// 64-bit mtime / mtimecmp, CTRL (bit0 EN) and an optional PRESCALE register.
// Reads are registered (1-cycle latency); the timer interrupt is the
// registered level (mtime >= mtimecmp).
//
// Build option: define MSRV32_MTIMER_PRESCALER_EN to add the 16-bit prescaler
// (msrv32_mtimer_prescaler). Without it mtime ticks every enabled cycle and
// PRESCALE reads 0.
//
// Ports:
//   ms_riscv32_mp_clk_in       - clock, rising edge
//   ms_riscv32_mp_rst_in       - synchronous active-high reset
//   ms_riscv32_mp_dmaddr_in    - core data address
//   ms_riscv32_mp_dmdata_in    - core store data
//   ms_riscv32_mp_dmwr_req_in  - core write strobe
//   ms_riscv32_mp_dmwr_mask_in - byte enables, bit n enables byte n
//   rd_data_out                - registered read data (0 when no hit)
//   rd_hit_out                 - registered: rd_data_out came from this window
//   ms_riscv32_mp_rc_out       - current mtime
//   ms_riscv32_mp_tirq_out     - registered timer interrupt level
// ----------------------------------------------------------------------------
module msrv32_mtimer
  import msrv32_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_4000
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  output logic [31:0] rd_data_out,
  output logic        rd_hit_out,
  output logic [63:0] ms_riscv32_mp_rc_out,
  output logic        ms_riscv32_mp_tirq_out
);

  logic        clk;
  logic        rst;
  logic [31:0] wdata;
  logic [3:0]  wmask;

  assign clk   = ms_riscv32_mp_clk_in;
  assign rst   = ms_riscv32_mp_rst_in;
  assign wdata = ms_riscv32_mp_dmdata_in;
  assign wmask = ms_riscv32_mp_dmwr_mask_in;

  // Byte-lane bits never select a register.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^ms_riscv32_mp_dmaddr_in[1:0];

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic       hit;
  logic [2:0] off;
  logic       wr;

  assign hit = (ms_riscv32_mp_dmaddr_in[31:5] == BASE_ADDR[31:5]);
  assign off = ms_riscv32_mp_dmaddr_in[4:2];
  assign wr  = hit && ms_riscv32_mp_dmwr_req_in;

  // --------------------------------------------------------------------------
  // Registers and tick generation
  // --------------------------------------------------------------------------
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        en;
  logic        tick;

`ifdef MSRV32_MTIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] prescale;
  logic                  prescale_wr;

  assign prescale_wr = wr && (off == OFF_PRESCALE);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
    end else if (prescale_wr) begin
      if (wmask[0]) prescale[7:0]  <= wdata[7:0];
      if (wmask[1]) prescale[15:8] <= wdata[15:8];
    end
  end

  msrv32_mtimer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clear    (prescale_wr),
    .prescale (prescale),
    .tick     (tick)
  );
`else
  assign tick = en;
`endif

  // A software write to either mtime half wins over the tick in that cycle;
  // the other half holds, so a discarded tick never carries.
  // NOTE: state registers use non-blocking assignments so every always_ff
  // samples the same pre-edge values (this is what makes reads and tirq see
  // pre-write contents).
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
    end else if (wr && (off == OFF_MTIME_LO)) begin
      mtime[31:0] <= byte_merge(mtime[31:0], wdata, wmask);
    end else if (wr && (off == OFF_MTIME_HI)) begin
      mtime[63:32] <= byte_merge(mtime[63:32], wdata, wmask);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= MTIMECMP_RST;
    end else if (wr && (off == OFF_MTIMECMP_LO)) begin
      mtimecmp[31:0] <= byte_merge(mtimecmp[31:0], wdata, wmask);
    end else if (wr && (off == OFF_MTIMECMP_HI)) begin
      mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], wdata, wmask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en <= 1'b1;
    end else if (wr && (off == OFF_CTRL) && wmask[0]) begin
      en <= wdata[CTRL_EN_BIT];
    end
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  logic [31:0] rd_next;

  // NOTE: rd_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_next = '0;
    if (hit) begin
      case (off)
        OFF_MTIME_LO:    rd_next = mtime[31:0];
        OFF_MTIME_HI:    rd_next = mtime[63:32];
        OFF_MTIMECMP_LO: rd_next = mtimecmp[31:0];
        OFF_MTIMECMP_HI: rd_next = mtimecmp[63:32];
        OFF_CTRL:        rd_next[CTRL_EN_BIT] = en;
`ifdef MSRV32_MTIMER_PRESCALER_EN
        OFF_PRESCALE:    rd_next[PRESCALE_W-1:0] = prescale;
`endif
        default:         rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_out <= '0;
      rd_hit_out  <= 1'b0;
    end else begin
      rd_data_out <= rd_next;
      rd_hit_out  <= hit;
    end
  end

  // --------------------------------------------------------------------------
  // Interrupt and real-time counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) ms_riscv32_mp_tirq_out <= 1'b0;
    else     ms_riscv32_mp_tirq_out <= (mtime >= mtimecmp);
  end

  assign ms_riscv32_mp_rc_out = mtime;

endmodule

// File: tb/tb_msrv32_mtimer.sv
// ----------------------------------------------------------------------------
// tb_msrv32_mtimer
// Directed testbench for msrv32_mtimer. Inputs change 1 ns after a rising
// edge; outputs are sampled at the same point, i.e. after the edge has
// settled. With MSRV32_MTIMER_PRESCALER_EN defined the prescaler scenario
// runs; otherwise PRESCALE is checked to read 0.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_msrv32_mtimer;

  localparam logic [31:0] BASE = 32'h0200_4000;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr_req;
  logic [3:0]  wmask;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic [63:0] rc;
  logic        tirq;

  int checks   = 0;
  int failures = 0;

  msrv32_mtimer #(.BASE_ADDR(BASE)) dut (
    .ms_riscv32_mp_clk_in       (clk),
    .ms_riscv32_mp_rst_in       (rst),
    .ms_riscv32_mp_dmaddr_in    (addr),
    .ms_riscv32_mp_dmdata_in    (wdata),
    .ms_riscv32_mp_dmwr_req_in  (wr_req),
    .ms_riscv32_mp_dmwr_mask_in (wmask),
    .rd_data_out                (rd_data),
    .rd_hit_out                 (rd_hit),
    .ms_riscv32_mp_rc_out       (rc),
    .ms_riscv32_mp_tirq_out     (tirq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [31:0] d,
                           input logic [3:0] m);
    addr   = BASE + {27'd0, off, 2'b00};
    wdata  = d;
    wmask  = m;
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] off);
    addr = BASE + {27'd0, off, 2'b00};
    step();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) step();
    checks++;
    if (rc !== 64'd0) begin
      $display("FAIL reset_rc got=%h exp=%h", rc, 64'd0); failures++;
    end
    checks++;
    if (tirq !== 1'b0) begin
      $display("FAIL reset_tirq got=%b exp=0", tirq); failures++;
    end
    checks++;
    if (rd_hit !== 1'b0 || rd_data !== 32'd0) begin
      $display("FAIL reset_rd got hit=%b data=%h exp hit=0 data=0", rd_hit, rd_data);
      failures++;
    end
    // Reset overrides a write landing in the same cycle.
    addr = BASE; wdata = 32'd123; wmask = 4'hF; wr_req = 1'b1;
    step();
    checks++;
    if (rc !== 64'd0) begin
      $display("FAIL reset_override got=%h exp=%h", rc, 64'd0); failures++;
    end
    wr_req = 1'b0;
    addr   = 32'd0;
    rst    = 1'b0;
  endtask

  task automatic test_count();
    repeat (10) step();
    checks++;
    if (rc !== 64'd10) begin
      $display("FAIL count10_rc got=%0d exp=10", rc); failures++;
    end
    checks++;
    if (tirq !== 1'b0) begin
      $display("FAIL count10_tirq got=%b exp=0", tirq); failures++;
    end
    bus_read(3'd3);
    checks++;
    if (rd_data !== 32'hFFFF_FFFF) begin
      $display("FAIL cmp_hi_reset got=%h exp=ffffffff", rd_data); failures++;
    end
    bus_read(3'd4);
    checks++;
    if (rd_data !== 32'd1) begin
      $display("FAIL ctrl_reset got=%h exp=00000001", rd_data); failures++;
    end
  endtask

  task automatic test_compare();
    bus_write(3'd4, 32'd0, 4'hF);
    bus_write(3'd0, 32'd0, 4'hF);
    bus_write(3'd1, 32'd0, 4'hF);
    bus_write(3'd2, 32'd20, 4'hF);
    bus_write(3'd3, 32'd0, 4'hF);
    bus_write(3'd4, 32'd1, 4'hF);
    checks++;
    if (rc !== 64'd0) begin
      $display("FAIL cmp_start got=%0d exp=0", rc); failures++;
    end
    for (int i = 0; i < 50 && rc !== 64'd20; i++) step();
    checks++;
    if (rc !== 64'd20) begin
      $display("FAIL cmp_reach20 got=%0d exp=20 (timeout)", rc); failures++;
    end
    checks++;
    if (tirq !== 1'b0) begin
      $display("FAIL tirq_at20 got=%b exp=0", tirq); failures++;
    end
    step();
    checks++;
    if (tirq !== 1'b1 || rc !== 64'd21) begin
      $display("FAIL tirq_rise got tirq=%b rc=%0d exp tirq=1 rc=21", tirq, rc);
      failures++;
    end
    bus_write(3'd3, 32'd1, 4'hF);
    checks++;
    if (tirq !== 1'b1) begin
      $display("FAIL tirq_preedge got=%b exp=1", tirq); failures++;
    end
    step();
    checks++;
    if (tirq !== 1'b0) begin
      $display("FAIL tirq_fall got=%b exp=0", tirq); failures++;
    end
  endtask

  task automatic test_carry();
    bus_write(3'd4, 32'd0, 4'hF);
    bus_write(3'd0, 32'hFFFF_FFFF, 4'hF);
    bus_write(3'd1, 32'd0, 4'hF);
    bus_write(3'd4, 32'd1, 4'hF);
    checks++;
    if (rc !== 64'h0000_0000_FFFF_FFFF) begin
      $display("FAIL carry_setup got=%h exp=00000000ffffffff", rc); failures++;
    end
    step();
    checks++;
    if (rc !== 64'h0000_0001_0000_0000) begin
      $display("FAIL carry got=%h exp=0000000100000000", rc); failures++;
    end
  endtask

  task automatic test_byte_mask();
    bus_write(3'd4, 32'd0, 4'hF);
    checks++;
    if (rc !== 64'h0000_0001_0000_0001) begin
      $display("FAIL freeze_tick got=%h exp=0000000100000001", rc); failures++;
    end
    bus_write(3'd1, 32'h0000_AB00, 4'b0010);
    checks++;
    if (rc !== 64'h0000_AB01_0000_0001) begin
      $display("FAIL byte_mask got=%h exp=0000ab0100000001", rc); failures++;
    end
    repeat (3) step();
    checks++;
    if (rc !== 64'h0000_AB01_0000_0001) begin
      $display("FAIL freeze_hold got=%h exp=0000ab0100000001", rc); failures++;
    end
  endtask

  task automatic test_read();
    bus_read(3'd1);
    checks++;
    if (rd_data !== 32'h0000_AB01 || rd_hit !== 1'b1) begin
      $display("FAIL read_hi got data=%h hit=%b exp data=0000ab01 hit=1", rd_data, rd_hit);
      failures++;
    end
    addr = BASE + 32'd32;
    step();
    checks++;
    if (rd_data !== 32'd0 || rd_hit !== 1'b0) begin
      $display("FAIL read_outside got data=%h hit=%b exp data=0 hit=0", rd_data, rd_hit);
      failures++;
    end
    bus_write(3'd6, 32'hDEAD_BEEF, 4'hF);
    bus_read(3'd6);
    checks++;
    if (rd_data !== 32'd0 || rd_hit !== 1'b1) begin
      $display("FAIL read_reserved got data=%h hit=%b exp data=0 hit=1", rd_data, rd_hit);
      failures++;
    end
    bus_read(3'd4);
    checks++;
    if (rd_data !== 32'd0) begin
      $display("FAIL read_ctrl_off got=%h exp=0", rd_data); failures++;
    end
  endtask

  task automatic test_read_during_write();
    bus_write(3'd2, 32'h0000_0055, 4'hF);
    checks++;
    if (rd_data !== 32'd20) begin
      $display("FAIL rdw_old got=%h exp=00000014", rd_data); failures++;
    end
    step();
    checks++;
    if (rd_data !== 32'h0000_0055) begin
      $display("FAIL rdw_new got=%h exp=00000055", rd_data); failures++;
    end
  endtask

  task automatic test_write_priority();
    bus_write(3'd4, 32'd1, 4'hF);
    bus_write(3'd0, 32'hFFFF_FFFF, 4'hF);
    checks++;
    if (rc !== 64'h0000_AB01_FFFF_FFFF) begin
      $display("FAIL wr_prio1 got=%h exp=0000ab01ffffffff", rc); failures++;
    end
    bus_write(3'd0, 32'hFFFF_FFFF, 4'hF);
    checks++;
    if (rc !== 64'h0000_AB01_FFFF_FFFF) begin
      $display("FAIL wr_prio_nocarry got=%h exp=0000ab01ffffffff", rc); failures++;
    end
    bus_write(3'd4, 32'd0, 4'hF);
    checks++;
    if (rc !== 64'h0000_AB02_0000_0000) begin
      $display("FAIL tick_carry got=%h exp=0000ab0200000000", rc); failures++;
    end
  endtask

`ifdef MSRV32_MTIMER_PRESCALER_EN
  task automatic test_prescaler();
    bus_write(3'd5, 32'd3, 4'hF);
    bus_write(3'd0, 32'd0, 4'hF);
    bus_write(3'd1, 32'd0, 4'hF);
    bus_read(3'd5);
    checks++;
    if (rd_data !== 32'd3) begin
      $display("FAIL prescale_read got=%h exp=3", rd_data); failures++;
    end
    bus_write(3'd4, 32'd1, 4'hF);
    repeat (12) step();
    checks++;
    if (rc !== 64'd3) begin
      $display("FAIL prescale12 got=%0d exp=3", rc); failures++;
    end
    bus_write(3'd4, 32'd0, 4'hF);
    repeat (8) step();
    checks++;
    if (rc !== 64'd3) begin
      $display("FAIL prescale_hold got=%0d exp=3", rc); failures++;
    end
  endtask
`else
  task automatic test_prescaler();
    bus_write(3'd5, 32'h0000_FFFF, 4'hF);
    bus_read(3'd5);
    checks++;
    if (rd_data !== 32'd0 || rd_hit !== 1'b1) begin
      $display("FAIL prescale_absent got data=%h hit=%b exp data=0 hit=1", rd_data, rd_hit);
      failures++;
    end
    checks++;
    if (rc !== 64'h0000_AB02_0000_0000) begin
      $display("FAIL disabled_hold got=%h exp=0000ab0200000000", rc); failures++;
    end
  endtask
`endif

  initial begin
    rst    = 1'b1;
    addr   = 32'd0;
    wdata  = 32'd0;
    wr_req = 1'b0;
    wmask  = 4'h0;
    test_reset();
    test_count();
    test_compare();
    test_carry();
    test_byte_mask();
    test_read();
    test_read_during_write();
    test_write_priority();
    test_prescaler();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
